lemon_mem_arb: RTL and testbench
================================

# lemon_mem_arb

- Shares the single LemonPC memory port between the instruction-fetch path (IFU, read-only) and the load/store path (LSU, read/write).
- Accepts one request at a time through valid/ready handshakes and holds it in internal registers.
- Drives the request on the memory port until the memory accepts it, waits for the response, then returns it to the requester that owns the transaction.
- Sits between the fetch/LSU logic, which is sequenced by the instruction decoder's `mem_wen`/`mem_ren`/`mem_mask` controls, and the memory model.

## Interface
Parameters:
- `AW`, default 64: address width.
- `DW`, default 64: data width.
- `MW`, default 8: byte-mask width, equal to DW/8.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `if_req_valid`  in  1  IFU read request.
- `if_req_addr`  in  AW  IFU address.
- `if_req_ready`  out  1  IFU request accepted this cycle.
- `if_rsp_valid`  out  1  one-cycle IFU response pulse.
- `if_rsp_data`  out  DW  read data for the IFU.
- `ls_req_valid`  in  1  LSU request.
- `ls_req_wen`  in  1  1 = write, 0 = read.
- `ls_req_addr`  in  AW  LSU address.
- `ls_req_wdata`  in  DW  LSU write data.
- `ls_req_mask`  in  MW  LSU byte mask.
- `ls_req_ready`  out  1  LSU request accepted this cycle.
- `ls_rsp_valid`  out  1  one-cycle LSU response pulse; asserted for writes as well as reads.
- `ls_rsp_data`  out  DW  read data for the LSU; 0 on writes.
- `mem_req_valid`  out  1  memory request.
- `mem_req_wen`  out  1  memory write enable.
- `mem_req_addr`  out  AW  memory address.
- `mem_req_wdata`  out  DW  memory write data.
- `mem_req_mask`  out  MW  memory byte mask.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_rsp_valid`  in  1  memory response.
- `mem_rsp_data`  in  DW  memory read data.

## Operation
FSM states: IDLE, REQ, WAIT, RSP. An owner flag records the current requester (IF or LS).

IDLE
- `if_req_ready` is asserted when `if_req_valid` is high and the IFU is the arbitration winner; `ls_req_ready` likewise for the LSU.
- At most one ready is high per cycle.
- On acceptance, the arbiter latches the request fields into the hold registers, sets the owner, and goes to REQ.

Arbitration when both requesters are valid
- The winner is the requester not granted last.
- `last_grant` resets to IF, so the LSU wins the first tie.
- If only one requester is valid, it wins.

Request latching
- An IFU request is latched as `wen=0` with mask all-ones (`{MW{1'b1}}`).
- `wdata` is latched as 0.

REQ
- `mem_req_valid=1`, with all `mem_req_*` driven from the hold registers.
- The hold registers stay stable until `mem_req_ready`.
- On `mem_req_valid && mem_req_ready`, go to WAIT.

WAIT
- On `mem_rsp_valid`, latch `mem_rsp_data`, then go to RSP.
- For a write, the latched data value is 0.
- A `mem_rsp_valid` seen in any state other than WAIT is ignored.

RSP
- The owner's `*_rsp_valid` is 1 for exactly one cycle, with the latched data on its `*_rsp_data`.
- `last_grant` is updated to the owner. Go to IDLE.
- No new request is accepted in RSP; requesters have no response backpressure.

Output rules
- The `*_rsp_data` outputs of the non-owner read 0.
- `mem_req_*` are 0 outside REQ.

Reset
- With `rst_n=0` at a clock edge: state becomes IDLE, `last_grant`=IF, all hold registers are cleared and all outputs are 0.
- Any in-flight transaction is abandoned and no response is delivered.
- A `mem_rsp_valid` arriving after reset is ignored, because the FSM is in IDLE.

## Timing
- Reset value of every output is 0.
- Ready outputs are combinational from IDLE state, the two `req_valid` inputs and `last_grant`.
- All other outputs are registered or decoded from state and registers only; there is no combinational path from `mem_*` inputs to requester outputs.
- Minimum latency: request accepted in cycle 0; `mem_req_valid` in cycle 1; with `mem_req_ready` in cycle 1 and `mem_rsp_valid` in cycle 2, the `*_rsp_valid` pulse appears in cycle 3.
- Back-to-back: the earliest next acceptance is the cycle after RSP, giving a throughput of one transaction per 4 cycles at best.
- Memory stall: REQ and WAIT hold indefinitely. There is no timeout.

## Structure
- FSM state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RSP=2'd3) and owner codes (`own_if`=1'b0, `own_ls`=1'b1) go in `defines.v`, alongside the existing `mem_mask_*` constants.
- The tie-break logic is a natural sub-module: `lemon_rr_arb2`, a 2-way round-robin arbiter with the `last_grant` register inside it and an update strobe.

## Test plan
1. Reset, then IFU reads `0x8000_0000`; memory ready immediately, responds next cycle with `0x0000_0013`. Required: `if_rsp_valid` pulses in cycle 3 with data `0x13`; `ls_rsp_valid` stays 0.
2. LSU write to `0x8000_0100`, wdata `0xDEAD_BEEF_CAFE_F00D`, mask `0xFF`. Required: `mem_req_*` matches exactly, `mem_req_wen`=1, and `ls_rsp_valid` pulses with data 0.
3. Both requesters held valid continuously from reset. Required: grants go LS, IF, LS, IF…, and each requester gets exactly 2 grants in 4 transactions.
4. `mem_req_ready` held low 5 cycles in REQ. Required: `mem_req_valid` and `addr` are stable for all 6 cycles, and `ls_req_ready` and `if_req_ready` are 0 throughout.
5. A spurious `mem_rsp_valid` in IDLE and in REQ. Required: no `*_rsp_valid` pulse and no state change.
6. `rst_n` asserted low for 1 cycle during WAIT, then `mem_rsp_valid` arrives. Required: all outputs 0 after the reset edge, no response delivered, and the next IFU request completes normally.

Source files
------------

// File: rtl/lemon_mem_arb_pkg.sv
// lemon_mem_arb shared types and constants.
// FSM encodings, owner codes and memory byte-mask presets.
package lemon_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [7:0] MEM_MASK_B = 8'h01;
  localparam logic [7:0] MEM_MASK_H = 8'h03;
  localparam logic [7:0] MEM_MASK_W = 8'h0F;
  localparam logic [7:0] MEM_MASK_D = 8'hFF;

endpackage

// File: rtl/lemon_mem_arb_if.sv
// Requester and memory-port bundle for lemon_mem_arb.
// slave = arbiter view, master = environment view.
interface lemon_mem_arb_if #(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int MW = 8
);
  logic          if_req_valid;
  logic [AW-1:0] if_req_addr;
  logic          if_req_ready;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;

  logic          ls_req_valid;
  logic          ls_req_wen;
  logic [AW-1:0] ls_req_addr;
  logic [DW-1:0] ls_req_wdata;
  logic [MW-1:0] ls_req_mask;
  logic          ls_req_ready;
  logic          ls_rsp_valid;
  logic [DW-1:0] ls_rsp_data;

  logic          mem_req_valid;
  logic          mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [MW-1:0] mem_req_mask;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_req_wen, ls_req_addr,
    input  ls_req_wdata, ls_req_mask,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_req_valid, mem_req_wen, mem_req_addr,
    output mem_req_wdata, mem_req_mask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_req_wen, ls_req_addr,
    output ls_req_wdata, ls_req_mask,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_req_valid, mem_req_wen, mem_req_addr,
    input  mem_req_wdata, mem_req_mask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/lemon_mem_arb_rr.sv
// 2-way round-robin arbiter; bit 0 = IF, bit 1 = LS.
// last_grant only moves on the upd strobe, not on grant.
module lemon_rr_arb2
  import lemon_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_q == OWN_IF) ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    last_d = last_q;
    if (upd) last_d = upd_id;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= OWN_IF;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/lemon_mem_arb.sv
// Shares one memory port between IFU and LSU.
// One transaction in flight: IDLE -> REQ -> WAIT -> RSP.
module lemon_mem_arb
  import lemon_mem_arb_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int MW = 8
) (
  input logic            clk,
  input logic            rst_n,
  lemon_mem_arb_if.slave bus
);

  state_e        state_q, state_d;
  logic          own_q, own_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [MW-1:0] mask_q, mask_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [1:0] gnt;
  logic       idle;
  logic       req_st;
  logic       rsp_st;

  assign idle   = (state_q == ST_IDLE);
  assign req_st = (state_q == ST_REQ);
  assign rsp_st = (state_q == ST_RSP);

  lemon_rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({bus.ls_req_valid & idle,
              bus.if_req_valid & idle}),
    .upd    (rsp_st),
    .upd_id (own_q),
    .gnt    (gnt)
  );

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt[OWN_LS]) begin
          own_d   = OWN_LS;
          wen_d   = bus.ls_req_wen;
          addr_d  = bus.ls_req_addr;
          wdata_d = bus.ls_req_wdata;
          mask_d  = bus.ls_req_mask;
          state_d = ST_REQ;
        end else if (gnt[OWN_IF]) begin
          own_d   = OWN_IF;
          wen_d   = 1'b0;
          addr_d  = bus.if_req_addr;
          wdata_d = '0;
          mask_d  = {MW{1'b1}};
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid) begin
          // writes hand back zero whatever memory drives
          rdata_d = wen_q ? '0 : bus.mem_rsp_data;
          state_d = ST_RSP;
        end
      end
      ST_RSP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      own_q   <= OWN_IF;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.if_req_ready = gnt[OWN_IF];
  assign bus.ls_req_ready = gnt[OWN_LS];

  assign bus.mem_req_valid = req_st;
  assign bus.mem_req_wen   = req_st & wen_q;
  assign bus.mem_req_addr  = req_st ? addr_q  : '0;
  assign bus.mem_req_wdata = req_st ? wdata_q : '0;
  assign bus.mem_req_mask  = req_st ? mask_q  : '0;

  assign bus.if_rsp_valid = rsp_st & (own_q == OWN_IF);
  assign bus.ls_rsp_valid = rsp_st & (own_q == OWN_LS);
  assign bus.if_rsp_data  = bus.if_rsp_valid ? rdata_q : '0;
  assign bus.ls_rsp_data  = bus.ls_rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_lemon_mem_arb.sv
// Bench for lemon_mem_arb: directed stimulus,
// queued expected responses checked by a monitor.
module tb_lemon_mem_arb;

  logic clk = 1'b0;
  logic rst_n;

  lemon_mem_arb_if #(.AW(64), .DW(64), .MW(8)) bus ();

  lemon_mem_arb #(.AW(64), .DW(64), .MW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        own;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ls_gnt = 0;
  int   if_gnt = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h",
               nm, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_rsp(input logic own,
                            input logic [63:0] d);
    exp_t e;
    e.own  = own;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle_in();
    bus.if_req_valid  = 1'b0;
    bus.if_req_addr   = '0;
    bus.ls_req_valid  = 1'b0;
    bus.ls_req_wen    = 1'b0;
    bus.ls_req_addr   = '0;
    bus.ls_req_wdata  = '0;
    bus.ls_req_mask   = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, 64'({bus.if_req_ready,
        bus.ls_req_ready, bus.if_rsp_valid,
        bus.ls_rsp_valid, bus.mem_req_valid,
        bus.mem_req_wen, bus.mem_req_mask}), 64'd0);
    chk({nm, "_data"}, bus.mem_req_addr
        | bus.mem_req_wdata | bus.if_rsp_data
        | bus.ls_rsp_data, 64'd0);
  endtask

  // Accept mem request, respond the next cycle.
  task automatic serve(input logic [63:0] rd);
    int n = 0;
    while (bus.mem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.mem_req_valid !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL serve_timeout: got %b, required 1",
               bus.mem_req_valid);
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = rd;
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.if_rsp_valid || bus.ls_rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_rsp: got if=%0b ls=%0b, required none",
                 bus.if_rsp_valid, bus.ls_rsp_valid);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_both", 64'(bus.if_rsp_valid
            & bus.ls_rsp_valid), 64'd0);
        chk("rsp_owner", 64'(bus.ls_rsp_valid),
            64'(e.own));
        chk("rsp_data", e.own ? bus.ls_rsp_data
            : bus.if_rsp_data, e.data);
        chk("rsp_other_data", e.own ? bus.if_rsp_data
            : bus.ls_rsp_data, 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk_all_zero("reset");

    // 1: IFU read, minimum latency
    expect_rsp(1'b0, 64'h13);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h8000_0000;
    #1;
    chk("t1_if_ready", 64'(bus.if_req_ready), 64'd1);
    chk("t1_ls_ready", 64'(bus.ls_req_ready), 64'd0);
    tick();
    bus.if_req_valid = 1'b0;
    chk("t1_mem_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("t1_mem_addr", bus.mem_req_addr, 64'h8000_0000);
    chk("t1_wen_mask", 64'({bus.mem_req_wen,
        bus.mem_req_mask}), 64'h0FF);
    chk("t1_wdata", bus.mem_req_wdata, 64'd0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    chk("t1_mem_drop", 64'(bus.mem_req_valid), 64'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'h13;
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    chk("t1_if_rsp_c3", 64'(bus.if_rsp_valid), 64'd1);
    chk("t1_ls_rsp", 64'(bus.ls_rsp_valid), 64'd0);
    tick();
    chk("t1_pulse_end", 64'({bus.if_rsp_valid,
        bus.ls_rsp_valid}), 64'd0);

    // 2: LSU write, response data must be 0
    expect_rsp(1'b1, 64'd0);
    bus.ls_req_valid = 1'b1;
    bus.ls_req_wen   = 1'b1;
    bus.ls_req_addr  = 64'h8000_0100;
    bus.ls_req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    bus.ls_req_mask  = 8'hFF;
    #1;
    chk("t2_ls_ready", 64'(bus.ls_req_ready), 64'd1);
    tick();
    bus.ls_req_valid = 1'b0;
    bus.ls_req_wen   = 1'b0;
    bus.ls_req_wdata = '0;
    chk("t2_valid_wen", 64'({bus.mem_req_valid,
        bus.mem_req_wen}), 64'd3);
    chk("t2_addr", bus.mem_req_addr, 64'h8000_0100);
    chk("t2_wdata", bus.mem_req_wdata,
        64'hDEAD_BEEF_CAFE_F00D);
    chk("t2_mask", 64'(bus.mem_req_mask), 64'hFF);
    serve(64'h1234_5678_9ABC_DEF0);
    tick();

    // 3: both valid from reset, LS wins first
    do_reset();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h8000_1000;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 64'h8000_2000;
    bus.ls_req_mask  = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_ls_ready", 64'(bus.ls_req_ready),
          64'(i % 2 == 0));
      chk("t3_if_ready", 64'(bus.if_req_ready),
          64'(i % 2 == 1));
      ls_gnt += int'(bus.ls_req_ready);
      if_gnt += int'(bus.if_req_ready);
      expect_rsp(i % 2 == 0, 64'h100 + 64'(i));
      tick();
      chk("t3_addr", bus.mem_req_addr, (i % 2 == 0)
          ? 64'h8000_2000 : 64'h8000_1000);
      serve(64'h100 + 64'(i));
      #1;
      chk("t3_rsp_no_ready", 64'({bus.if_req_ready,
          bus.ls_req_ready}), 64'd0);
      tick();
    end
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    chk("t3_ls_grants", 64'(ls_gnt), 64'd2);
    chk("t3_if_grants", 64'(if_gnt), 64'd2);
    tick();

    // 4: memory stall in REQ
    expect_rsp(1'b1, 64'hABCD);
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 64'h8000_3000;
    #1;
    chk("t4_ls_ready", 64'(bus.ls_req_ready), 64'd1);
    tick();
    bus.ls_req_addr  = 64'h8000_4000;
    bus.if_req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t4_valid", 64'(bus.mem_req_valid), 64'd1);
      chk("t4_addr", bus.mem_req_addr, 64'h8000_3000);
      chk("t4_readies", 64'({bus.if_req_ready,
          bus.ls_req_ready}), 64'd0);
      if (k == 5) begin
        bus.mem_req_ready = 1'b1;
        bus.if_req_valid  = 1'b0;
        bus.ls_req_valid  = 1'b0;
      end
      tick();
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hABCD;
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    tick();

    // 5: spurious mem response in IDLE and REQ
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hBAD;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("t5_idle_req", 64'(bus.mem_req_valid), 64'd0);
    chk("t5_idle_rsp", 64'({bus.if_rsp_valid,
        bus.ls_rsp_valid}), 64'd0);
    tick();
    chk("t5_idle_rsp2", 64'({bus.if_rsp_valid,
        bus.ls_rsp_valid, bus.mem_req_valid}), 64'd0);
    expect_rsp(1'b0, 64'h600D);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h8000_5000;
    #1;
    chk("t5_if_ready", 64'(bus.if_req_ready), 64'd1);
    tick();
    bus.if_req_valid  = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hBAD;
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    chk("t5_req_hold", 64'(bus.mem_req_valid), 64'd1);
    chk("t5_req_addr", bus.mem_req_addr, 64'h8000_5000);
    chk("t5_req_rsp", 64'({bus.if_rsp_valid,
        bus.ls_rsp_valid}), 64'd0);
    serve(64'h600D);
    tick();

    // 6: reset during WAIT abandons the transaction
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h8000_6000;
    tick();
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'h777;
    chk_all_zero("t6_post_rst");
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    chk_all_zero("t6_ignored");
    tick();
    chk_all_zero("t6_still_idle");
    expect_rsp(1'b0, 64'h13579);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h8000_7000;
    #1;
    chk("t6_if_ready", 64'(bus.if_req_ready), 64'd1);
    tick();
    bus.if_req_valid = 1'b0;
    chk("t6_addr", bus.mem_req_addr, 64'h8000_7000);
    serve(64'h13579);
    tick();
    tick();

    chk("pending_rsp", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
